// File: rtl/gray_accumulator.sv
// gray_accumulator
//   Streaming frame accumulator that stays in the gray domain at its
//   boundary. An internal gray_code_adder adds the running gray total (a)
//   and the incoming gray sample (b). At frame end the gray total, the
//   saturating carry-out count and the saturating sample count are
//   presented on a valid/ready output port.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous frame abort (wins over any handshake)
//   in_valid   in   sample valid
//   in_ready   out  sample can be accepted (registered)
//   in_gray    in   [WIDTH] gray-coded sample
//   in_last    in   sample closes the frame
//   out_valid  out  frame result valid (registered)
//   out_ready  in   downstream takes the result
//   out_sum    out  [WIDTH] gray frame total mod 2^WIDTH
//   out_ovf    out  [CNT_W] adds that produced a carry, saturating
//   out_cnt    out  [CNT_W] samples in the frame, saturating

// Gray-in / gray-out adder: convert both operands to binary, add, and
// re-encode the wrapped sum. co is the binary carry out of the MSB.
module gray_code_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // Binary bit i is the XOR of all gray bits at and above i.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  logic [WIDTH-1:0] a_bin, b_bin;
  logic [WIDTH:0]   s_bin;

  always_comb begin
    a_bin = g2b(a);
    b_bin = g2b(b);
    s_bin = {1'b0, a_bin} + {1'b0, b_bin} + {{WIDTH{1'b0}}, ci};
    sum   = s_bin[WIDTH-1:0] ^ (s_bin[WIDTH-1:0] >> 1);
    co    = s_bin[WIDTH];
  end

endmodule

module gray_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {ACC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_co;
  logic             accept;
  logic [CNT_W-1:0] ovf_upd, cnt_upd;

  gray_code_adder #(.WIDTH(WIDTH)) u_add (
    .a   (acc_q),
    .b   (in_gray),
    .ci  (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  always_comb begin
    accept  = in_valid & in_ready_q & (state_q == ACC);
    ovf_upd = (add_co && ovf_q != '1) ? ovf_q + CNT_W'(1) : ovf_q;
    cnt_upd = (cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;

    if (clr) begin
      // Abort drops any accept or output handshake of this cycle; the
      // last published result fields are left as they were.
      state_d     = ACC;
      acc_d       = '0;
      ovf_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      unique case (state_q)
        ACC: begin
          // in_ready is 0 out of reset; this raises it on the first edge.
          in_ready_d = 1'b1;
          if (accept) begin
            acc_d = add_sum;
            ovf_d = ovf_upd;
            cnt_d = cnt_upd;
            if (in_last) begin
              state_d     = HOLD;
              out_sum_d   = add_sum;
              out_ovf_d   = ovf_upd;
              out_cnt_d   = cnt_upd;
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            state_d     = ACC;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            acc_d       = '0;
            ovf_d       = '0;
            cnt_d       = '0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_gray_accumulator.sv
// tb_gray_accumulator
//   Directed frames from the block's test plan followed by randomized
//   frames with random gaps, random out_ready and occasional clr. A
//   frame-level model (integer running total and sample count) predicts
//   each result; a negedge monitor also checks handshake timing.
module tb_gray_accumulator;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_ovf;
  logic [CNT_W-1:0] out_cnt;

  gray_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] to_gray(input int v);
    logic [WIDTH-1:0] b;
    b = WIDTH'(v);
    return b ^ (b >> 1);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH-1:0] s;
    int               o;
    int               c;
  } exp_t;

  exp_t expq[$];
  int   m_tot = 0;
  int   m_cnt = 0;
  int   drv_bin = 0;
  bit   mon_en = 0;
  bit   p_last = 0, p_hs = 0, p_clr = 0;
  localparam int SAT = (1 << CNT_W) - 1;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      m_tot = 0; m_cnt = 0; expq.delete();
      p_last = 0; p_hs = 0; p_clr = 0;
    end else begin
      chk("rdy_vs_ov", {31'b0, in_ready}, {31'b0, !out_valid});
      if (p_last) chk("ov_rise", {31'b0, out_valid}, 1);
      if (p_hs || p_clr) chk("ov_fall", {31'b0, out_valid}, 0);
      if (out_valid) begin
        if (expq.size() == 0) chk("ov_spur", {31'b0, out_valid}, 0);
        else begin
          chk("m_sum", {28'b0, out_sum}, {28'b0, expq[0].s});
          chk("m_ovf", {24'b0, out_ovf}, expq[0].o);
          chk("m_cnt", {24'b0, out_cnt}, expq[0].c);
        end
      end
      p_last = 0; p_hs = 0; p_clr = 0;
      if (clr) begin
        m_tot = 0; m_cnt = 0; expq.delete(); p_clr = 1;
      end else begin
        if (out_valid && out_ready) begin
          if (expq.size() > 0) void'(expq.pop_front());
          p_hs = 1;
        end
        if (in_valid && in_ready) begin
          exp_t e;
          m_tot += drv_bin;
          m_cnt++;
          if (in_last) begin
            e.s = to_gray(m_tot % (1 << WIDTH));
            e.o = ((m_tot >> WIDTH) > SAT) ? SAT : (m_tot >> WIDTH);
            e.c = (m_cnt > SAT) ? SAT : m_cnt;
            expq.push_back(e);
            m_tot = 0; m_cnt = 0; p_last = 1;
          end
        end
      end
    end
  end

  // ---------------- random background drivers ----------------
  bit rand_ordy = 0;
  bit rand_clr  = 0;

  always @(posedge clk) begin
    #1;
    if (rand_ordy) out_ready = ($urandom_range(0, 2) != 0);
    if (rand_clr)  clr = ($urandom_range(0, 39) == 0);
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic wait_accept();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (i == 200) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input int v, input bit last);
    drv_bin  = v;
    in_gray  = to_gray(v);
    in_last  = last;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_out();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (i == 200) chk("out_timeout", 0, 1);
  endtask

  task automatic check_res(input string tag, input logic [WIDTH-1:0] s, input int o, input int c);
    chk({tag, "_sum"}, {28'b0, out_sum}, {28'b0, s});
    chk({tag, "_ovf"}, {24'b0, out_ovf}, o);
    chk({tag, "_cnt"}, {24'b0, out_cnt}, c);
  endtask

  task automatic do_reset();
    mon_en   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
    #2;
    chk("rst_ov",  {31'b0, out_valid}, 0);
    chk("rst_rdy", {31'b0, in_ready}, 0);
    chk("rst_sum", {28'b0, out_sum}, 0);
    chk("rst_ovf", {24'b0, out_ovf}, 0);
    chk("rst_cnt", {24'b0, out_cnt}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_pre_edge", {31'b0, in_ready}, 0);
    @(negedge clk);
    chk("rdy_post_edge", {31'b0, in_ready}, 1);
    mon_en = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Frame 1: 3 + 5 = 8.
    out_ready = 1'b1;
    send(3, 0); send(5, 1);
    wait_out();
    check_res("f1", 4'b1100, 0, 2);
    @(posedge clk); #1;

    // Frame 2: 9 + 9 = 18 -> one wrap.
    send(9, 0); send(9, 1);
    wait_out();
    check_res("f2", 4'b0011, 1, 2);
    @(posedge clk); #1;

    // Frame 3: single 15, result stalled 5 cycles with a sample pending.
    out_ready = 1'b0;
    send(15, 1);
    drv_bin = 3; in_gray = to_gray(3); in_last = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdy", {31'b0, in_ready}, 0);
      chk("stall_ov",  {31'b0, out_valid}, 1);
      check_res("stall", 4'b1000, 0, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    wait_out();
    check_res("f3next", 4'b0010, 0, 1);
    @(posedge clk); #1;

    // Frame 4: 300 x 1 -> count saturates, 18 wraps.
    for (int i = 0; i < 300; i++) send(1, i == 299);
    wait_out();
    check_res("f4", 4'b1010, 18, 255);
    @(posedge clk); #1;

    // Frame 5: abort after 3 samples with a 4th offered together with clr.
    send(4, 0); send(6, 0); send(7, 0);
    drv_bin = 8; in_gray = to_gray(8); in_last = 1'b0; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    send(2, 1);
    wait_out();
    check_res("f5", 4'b0011, 0, 1);
    @(posedge clk); #1;

    // Reset mid-frame, then reset while holding a result.
    send(5, 0); send(6, 0);
    do_reset();
    out_ready = 1'b0;
    send(7, 1);
    wait_out();
    chk("hold_before_rst", {31'b0, out_valid}, 1);
    do_reset();
    out_ready = 1'b1;

    // Randomized frames.
    rand_ordy = 1; rand_clr = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        send($urandom_range(0, (1 << WIDTH) - 1), i == n - 1);
      end
    end
    rand_ordy = 0; rand_clr = 0;
    clr = 1'b0; out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("drain", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_accumulator.md
# gray_accumulator

Streaming accumulator directly downstream of `gray_code_adder`. It consumes the adder's gray-coded `sum` and `co` and feeds the running total back to the adder's `a` input, so a frame of gray-coded samples is summed without leaving the gray domain at the boundary. At frame end it presents the gray-coded total, the carry-out count and the sample count on a valid/ready output port. It instantiates one `gray_code_adder` internally: `a`=accumulator, `b`=`in_gray`, `ci`=0.

## Interface
- `WIDTH`, 4, data width of samples and accumulator (gray code)
- `CNT_W`, 8, width of the sample counter and the overflow counter
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset: asynchronous, active-low
- `clr`  in  1  synchronous frame abort; highest priority after reset
- `in_valid`  in  1  sample valid
- `in_ready`  out  1  block can accept a sample (registered)
- `in_gray`  in  WIDTH  gray-coded sample
- `in_last`  in  1  sample is the final one of its frame
- `out_valid`  out  1  frame result valid (registered)
- `out_ready`  in  1  downstream accepts the result
- `out_sum`  out  WIDTH  gray-coded frame total, modulo 2^WIDTH
- `out_ovf`  out  CNT_W  number of accepted samples whose add produced `co`=1, saturating
- `out_cnt`  out  CNT_W  number of samples in the frame, saturating

## Operation
- States: ACC (accumulating) and HOLD (result presented). Reset state is ACC.
- Internal registers:
  - `acc`: WIDTH bits, gray, reset 0 (gray 0 = binary 0)
  - `ovf`: CNT_W bits, reset 0
  - `cnt`: CNT_W bits, reset 0
- Accept occurs when `in_valid & in_ready`. On accept in ACC:
  - `acc` <= adder `sum`
  - `ovf` increments if adder `co`=1; saturates at all-ones
  - `cnt` increments; saturates at all-ones
- ACC -> HOLD on an accept with `in_last`=1:
  - load `out_sum` with adder `sum`, `out_ovf` with updated `ovf`, `out_cnt` with updated `cnt`
  - set `out_valid`=1 and `in_ready`=0
- HOLD -> ACC when `out_valid & out_ready`:
  - `out_valid` <= 0, `in_ready` <= 1
  - `acc`, `ovf` and `cnt` <= 0
- In HOLD, `in_valid` is ignored and no sample is consumed.
- `clr`=1 in any state, next edge:
  - state to ACC; `acc`, `ovf`, `cnt` and `out_valid` to 0; `in_ready` to 1
  - a simultaneous accept or output handshake is discarded
- Arithmetic: the binary sum wraps modulo 2^WIDTH; each wrap is counted once via `co`. The true total equals `out_ovf`·2^WIDTH + bin(`out_sum`) as long as `out_ovf` has not saturated.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_cnt`=0
  - state ACC
- `in_ready` rises on the first rising edge after `rst_n` deasserts.
- Throughput is one sample per cycle in ACC. The combinational adder path fits in one cycle.
- Latency: `out_valid` asserts on the edge that accepts the `in_last` sample, so the result is visible 1 cycle after the last-beat cycle.
- Outputs hold stable while `out_valid & !out_ready`. `out_valid` never drops without a handshake, except on `clr` or reset.
- `in_ready` is high again in the cycle after the output handshake, giving a minimum 1-cycle bubble between frames.
- `out_sum`, `out_ovf` and `out_cnt` keep their last values after the handshake until the next frame end.
- Reset asserted mid-frame: all registers clear immediately (asynchronous), with no partial result emitted.

## Test plan
- Sequence: reset, then stream gray 0010 (3) and gray 0111 (5, `in_last`); `out_ready`=1 -> `out_sum`=1100 (8), `out_ovf`=0, `out_cnt`=2, `out_valid` high for exactly 1 cycle, `in_ready` high 1 cycle later.
- Stream gray 1101 (9), 1101 (9, last) -> `out_sum`=0011 (2), `out_ovf`=1, `out_cnt`=2.
- Single sample gray 1000 (15) with `in_last`, then `out_ready` low for 5 cycles while `in_valid` stays high -> `out_sum`=1000 and `out_cnt`=1 held stable, `in_ready`=0 throughout, no sample consumed; the next frame starts from `acc`=0 after the handshake.
- 300 samples of gray 0001 (1), last on #300 -> `out_cnt`=255 (saturated), `out_sum`=gray(300 mod 16 = 12)=1010, `out_ovf`=18.
- Accept 3 samples, pulse `clr` together with a 4th valid sample, then send gray 0011 (2, last) -> `out_sum`=0011, `out_cnt`=1, `out_ovf`=0.
- Drop `rst_n` mid-frame and while in HOLD -> all outputs 0 immediately, `in_ready`=0 during reset and 1 one edge after release.
